instr_mem_responder: RTL and testbench
======================================

INSTR_MEM_RESPONDER -- requirements
Module: instr_mem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, meaning instruction memory depth in 32-bit words.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0, meaning byte address of memory word 0.
REQ-003 SHALL have parameter LATENCY, default 1, meaning cycles from grant to rvalid; legal range 1..8.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 2, meaning maximum granted-but-unanswered requests; legal range 1..4.
REQ-005 SHALL have port clk  input  1  single clock; all flops on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port instr_req_i  input  1  fetch request.
REQ-008 SHALL have port instr_addr_i  input  32  fetch byte address; bits [1:0] ignored.
REQ-009 SHALL have port instr_gnt_o  output  1  request accepted this cycle.
REQ-010 SHALL have port instr_rvalid_o  output  1  response valid.
REQ-011 SHALL have port instr_rdata_o  output  32  response word.
REQ-012 SHALL have port instr_err_o  output  1  response is an error, qualified by rvalid.
REQ-013 SHALL have port busy_i  input  1  backpressure; suppresses grant.
REQ-014 SHALL have port mem_en_o  output  1  SRAM read enable.
REQ-015 SHALL have port mem_addr_o  output  clog2(MEM_WORDS)  SRAM word address.
REQ-016 SHALL have port mem_rdata_i  input  32  SRAM read data, valid one cycle after mem_en_o.

Function
REQ-017 instr_gnt_o SHALL be combinational: instr_req_i & ~busy_i & (outstanding < MAX_OUTSTANDING | instr_rvalid_o).
REQ-018 Address in range iff BASE_ADDR <= instr_addr_i < BASE_ADDR + 4*MEM_WORDS, with unsigned 32-bit compare and no wrap.
REQ-019 On a grant with in-range address, mem_en_o SHALL be 1 in the same cycle and mem_addr_o SHALL be (instr_addr_i - BASE_ADDR) >> 2.
REQ-020 On a grant with out-of-range address, mem_en_o SHALL be 0 and an error response SHALL be queued.
REQ-021 mem_en_o SHALL be 0 when there is no grant; mem_addr_o is don't-care then.
REQ-022 Every grant SHALL produce exactly one response, exactly LATENCY cycles later.
REQ-023 Responses SHALL be returned in grant order; one grant and one response per cycle maximum.
REQ-024 instr_rdata_o SHALL equal the SRAM word for valid responses, and 32'h0 when rvalid=0 or err=1.
REQ-025 instr_err_o SHALL be 0 whenever instr_rvalid_o=0.
REQ-026 For LATENCY>1, SRAM data SHALL be captured on the cycle after mem_en_o and carried through a delay line; the SRAM output is not assumed stable.
REQ-027 Outstanding counter width SHALL be clog2(MAX_OUTSTANDING+1).
REQ-028 Counter update rules:
 - +1 on grant only;
 - -1 on rvalid only;
 - unchanged on simultaneous grant and rvalid.
REQ-029 The counter SHALL never exceed MAX_OUTSTANDING and never underflow.
REQ-030 Already-granted requests SHALL be answered unconditionally; there is no abort, and busy_i does not stall responses.
REQ-031 When instr_req_i=1 and there is no grant, the requester holds the address; the block keeps no record of ungranted requests.

Reset
REQ-032 While rst=1:
 - instr_gnt_o=0, instr_rvalid_o=0, instr_rdata_o=0, instr_err_o=0, mem_en_o=0;
 - outstanding=0;
 - delay line cleared.
REQ-033 Reset mid-operation SHALL drop all in-flight responses; no rvalid SHALL appear for pre-reset grants.

Structure
REQ-034 Package instr_mem_pkg SHALL hold typedef resp_t {valid, err, data[31:0]} and constant WORD_BYTES=4.
REQ-035 Sub-module resp_delay_line SHALL implement the parameterized resp_t shift pipeline, with depth LATENCY-1 and 0 meaning pass-through.

Verification
REQ-036 Reset: assert rst with req=1, addr=0 -> gnt=0, rvalid=0, rdata=0; deassert -> gnt=1 in the first cycle.
REQ-037 Single read, LATENCY=1, mem[3]=32'h00A00093: req addr 32'hC at cycle t -> gnt at t, mem_en=1, mem_addr=3; rvalid at t+1 with rdata 32'h00A00093, err=0.
REQ-038 Throughput, LATENCY=3, MAX_OUTSTANDING=2, req held with addrs 0,4,8:
 - gnt at t and t+1; gnt=0 at t+2;
 - rvalid at t+3 with mem[0], and gnt for addr 8 in the same cycle;
 - rvalid at t+4 with mem[1], and at t+6 with mem[2].
REQ-039 Out of range, MEM_WORDS=1024, BASE_ADDR=0: addr 32'h1000 -> gnt=1, mem_en=0; rvalid at +LATENCY with err=1, rdata=0.
REQ-040 Backpressure: busy_i=1 for 5 cycles with req=1 -> no gnt and no mem_en; busy_i=0 -> gnt in the same cycle, response after LATENCY.
REQ-041 Reset mid-flight, LATENCY=3: grant at t, rst pulse at t+1 -> no rvalid at t+3; outstanding=0; next request is granted immediately.

Source files
------------

// File: rtl/instr_mem_pkg.sv
// Shared types for the instruction-memory responder: response record and word size.
package instr_mem_pkg;

    localparam int WORD_BYTES = 4;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] data;
    } resp_t;

    localparam resp_t RESP_IDLE = '{valid: 1'b0, err: 1'b0, data: 32'h0};

endpackage

// File: rtl/resp_delay_line.sv
// Fixed-depth shift pipeline for responses; DEPTH=0 is a straight wire.
module resp_delay_line
    import instr_mem_pkg::*;
#(
    parameter int DEPTH = 0
) (
    input  logic  clk,
    input  logic  rst,
    input  resp_t in_resp,
    output resp_t out_resp
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign out_resp       = in_resp;
        end else begin : g_pipe
            resp_t pipe [DEPTH];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) pipe[i] <= RESP_IDLE;
                end else begin
                    pipe[0] <= in_resp;
                    for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
                end
            end

            assign out_resp = pipe[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction fetch responder: grants fetches, reads a 1-cycle SRAM, returns
// in-order responses exactly LATENCY cycles after each grant.
module instr_mem_responder
    import instr_mem_pkg::*;
#(
    parameter int          MEM_WORDS       = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0,
    parameter int          LATENCY         = 1,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         instr_req_i,
    input  logic [31:0]                  instr_addr_i,
    output logic                         instr_gnt_o,
    output logic                         instr_rvalid_o,
    output logic [31:0]                  instr_rdata_o,
    output logic                         instr_err_o,
    input  logic                         busy_i,
    output logic                         mem_en_o,
    output logic [$clog2(MEM_WORDS)-1:0] mem_addr_o,
    input  logic [31:0]                  mem_rdata_i
);

    localparam int                AW       = $clog2(MEM_WORDS);
    localparam int                CNT_W    = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
    // 33-bit end bound so a region touching 4 GiB cannot wrap to zero
    localparam logic [32:0]       END_ADDR = {1'b0, BASE_ADDR} + 33'(WORD_BYTES * MEM_WORDS);

    logic [31:0]      offset;
    logic             in_range;
    logic [CNT_W-1:0] outstanding;
    logic             s1_valid;
    logic             s1_err;
    resp_t            s1_resp;
    resp_t            out_resp;

    assign offset   = instr_addr_i - BASE_ADDR;
    assign in_range = (instr_addr_i >= BASE_ADDR) && ({1'b0, instr_addr_i} < END_ADDR);

    // A response leaving this cycle frees its slot, so a full window can still grant.
    assign instr_gnt_o = instr_req_i & ~busy_i & ~rst &
                         ((outstanding < MAX_CNT) | instr_rvalid_o);
    assign mem_en_o    = instr_gnt_o & in_range;
    assign mem_addr_o  = AW'(offset >> $clog2(WORD_BYTES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
        end else begin
            s1_valid <= instr_gnt_o;
            s1_err   <= instr_gnt_o & ~in_range;
        end
    end

    // SRAM data is only trusted the cycle after the read; it is sampled here.
    assign s1_resp = '{valid: s1_valid,
                       err:   s1_err,
                       data:  (s1_valid & ~s1_err) ? mem_rdata_i : 32'h0};

    resp_delay_line #(
        .DEPTH (LATENCY - 1)
    ) u_delay (
        .clk      (clk),
        .rst      (rst),
        .in_resp  (s1_resp),
        .out_resp (out_resp)
    );

    assign instr_rvalid_o = out_resp.valid;
    assign instr_err_o    = out_resp.valid & out_resp.err;
    assign instr_rdata_o  = (out_resp.valid & ~out_resp.err) ? out_resp.data : 32'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            case ({instr_gnt_o, instr_rvalid_o})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench: one LATENCY=1 responder and one LATENCY=3 responder, each on its own SRAM model.
module tb_instr_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        busy;
    int          n_asrt;
    int          n_fail;

    logic        a_req, a_gnt, a_rvalid, a_err, a_mem_en;
    logic [31:0] a_addr, a_rdata, a_mem_rdata;
    logic [9:0]  a_mem_addr;

    logic        b_req, b_gnt, b_rvalid, b_err, b_mem_en;
    logic [31:0] b_addr, b_rdata, b_mem_rdata;
    logic [9:0]  b_mem_addr;

    logic [31:0] mem [1024];

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input int i);
        logic [15:0] lo;
        lo = 16'(i);
        return (i == 3) ? 32'h00A00093 : {16'hC0DE, lo};
    endfunction

    initial for (int i = 0; i < 1024; i++) mem[i] = word(i);

    // SRAM models return junk when not read, so a late capture shows up
    always @(posedge clk) a_mem_rdata <= a_mem_en ? mem[a_mem_addr] : 32'hDEADBEEF;
    always @(posedge clk) b_mem_rdata <= b_mem_en ? mem[b_mem_addr] : 32'hDEADBEEF;

    instr_mem_responder #(
        .MEM_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(1), .MAX_OUTSTANDING(2)
    ) a_dut (
        .clk(clk), .rst(rst),
        .instr_req_i(a_req), .instr_addr_i(a_addr), .instr_gnt_o(a_gnt),
        .instr_rvalid_o(a_rvalid), .instr_rdata_o(a_rdata), .instr_err_o(a_err),
        .busy_i(busy), .mem_en_o(a_mem_en), .mem_addr_o(a_mem_addr), .mem_rdata_i(a_mem_rdata)
    );

    instr_mem_responder #(
        .MEM_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(3), .MAX_OUTSTANDING(2)
    ) b_dut (
        .clk(clk), .rst(rst),
        .instr_req_i(b_req), .instr_addr_i(b_addr), .instr_gnt_o(b_gnt),
        .instr_rvalid_o(b_rvalid), .instr_rdata_o(b_rdata), .instr_err_o(b_err),
        .busy_i(busy), .mem_en_o(b_mem_en), .mem_addr_o(b_mem_addr), .mem_rdata_i(b_mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_asrt = 0; n_fail = 0;
        rst = 1'b1; busy = 1'b0;
        a_req = 1'b1; a_addr = 32'h0;
        b_req = 1'b0; b_addr = 32'h0;

        // reset holds everything quiet even with a request pending
        repeat (2) @(posedge clk);
        #2;
        chk("rst_gnt",    a_gnt,    0);
        chk("rst_rvalid", a_rvalid, 0);
        chk("rst_rdata",  a_rdata,  0);
        chk("rst_err",    a_err,    0);
        chk("rst_mem_en", a_mem_en, 0);
        chk("rst_b_gnt",  b_gnt,    0);
        rst = 1'b0; #1;
        chk("rel_gnt",      a_gnt,      1);
        chk("rel_mem_en",   a_mem_en,   1);
        chk("rel_mem_addr", a_mem_addr, 0);
        tick(); a_req = 1'b0; #1;
        chk("rel_rvalid", a_rvalid, 1);
        chk("rel_rdata",  a_rdata,  word(0));

        // single read at word 3
        tick(); a_req = 1'b1; a_addr = 32'hC; #1;
        chk("rd_gnt",      a_gnt,      1);
        chk("rd_mem_en",   a_mem_en,   1);
        chk("rd_mem_addr", a_mem_addr, 3);
        chk("rd_no_rv",    a_rvalid,   0);
        tick(); a_req = 1'b0; #1;
        chk("rd_rvalid", a_rvalid, 1);
        chk("rd_rdata",  a_rdata,  32'h00A00093);
        chk("rd_err",    a_err,    0);
        tick(); #1;
        chk("rd_idle_rv",    a_rvalid, 0);
        chk("rd_idle_rdata", a_rdata,  0);

        // last word in range, then first word out of range, back to back
        a_req = 1'b1; a_addr = 32'hFFC; #1;
        chk("top_gnt",      a_gnt,      1);
        chk("top_mem_en",   a_mem_en,   1);
        chk("top_mem_addr", a_mem_addr, 32'h3FF);
        tick(); a_addr = 32'h1000; #1;
        chk("oor_gnt",     a_gnt,    1);
        chk("oor_mem_en",  a_mem_en, 0);
        chk("top_rvalid",  a_rvalid, 1);
        chk("top_rdata",   a_rdata,  word(1023));
        tick(); a_req = 1'b0; #1;
        chk("oor_rvalid", a_rvalid, 1);
        chk("oor_err",    a_err,    1);
        chk("oor_rdata",  a_rdata,  0);

        // backpressure: five blocked cycles, then grant on release
        tick(); a_req = 1'b1; a_addr = 32'h20; busy = 1'b1; #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_gnt",    a_gnt,    0);
            chk("bp_mem_en", a_mem_en, 0);
            tick();
        end
        busy = 1'b0; #1;
        chk("bp_rel_gnt",  a_gnt,      1);
        chk("bp_rel_addr", a_mem_addr, 8);
        tick(); a_req = 1'b0; #1;
        chk("bp_rvalid", a_rvalid, 1);
        chk("bp_rdata",  a_rdata,  word(8));

        // throughput, LATENCY=3, window of 2
        tick(); b_req = 1'b1; b_addr = 32'h0; #1;
        chk("tp_t0_gnt", b_gnt, 1);
        tick(); b_addr = 32'h4; #1;
        chk("tp_t1_gnt", b_gnt, 1);
        tick(); b_addr = 32'h8; #1;
        chk("tp_t2_gnt", b_gnt,    0);
        chk("tp_t2_rv",  b_rvalid, 0);
        tick(); #1;
        chk("tp_t3_rv",    b_rvalid,   1);
        chk("tp_t3_rdata", b_rdata,    word(0));
        chk("tp_t3_gnt",   b_gnt,      1);
        chk("tp_t3_addr",  b_mem_addr, 2);
        tick(); b_req = 1'b0; #1;
        chk("tp_t4_rv",    b_rvalid, 1);
        chk("tp_t4_rdata", b_rdata,  word(1));
        tick(); #1;
        chk("tp_t5_rv", b_rvalid, 0);
        tick(); #1;
        chk("tp_t6_rv",    b_rvalid, 1);
        chk("tp_t6_rdata", b_rdata,  word(2));
        tick(); #1;
        chk("tp_t7_rv", b_rvalid, 0);

        // reset one cycle after a grant drops the in-flight response
        b_req = 1'b1; b_addr = 32'h10; #1;
        chk("mr_gnt", b_gnt, 1);
        tick(); rst = 1'b1; #1;
        chk("mr_rst_gnt", b_gnt,    0);
        chk("mr_rst_rv",  b_rvalid, 0);
        tick(); rst = 1'b0; b_req = 1'b0; #1;
        chk("mr_t2_rv", b_rvalid, 0);
        tick(); #1;
        chk("mr_t3_rv",  b_rvalid,          0);
        chk("mr_cnt",    b_dut.outstanding, 0);
        tick(); #1;
        chk("mr_t4_rv", b_rvalid, 0);
        // a full window of two must open again after reset
        b_req = 1'b1; b_addr = 32'h14; #1;
        chk("mr_n0_gnt",  b_gnt,      1);
        chk("mr_n0_addr", b_mem_addr, 5);
        tick(); b_addr = 32'h18; #1;
        chk("mr_n1_gnt", b_gnt, 1);
        tick(); b_addr = 32'h1C; #1;
        chk("mr_n2_gnt", b_gnt, 0);
        tick(); b_req = 1'b0; #1;
        chk("mr_n3_rv",    b_rvalid, 1);
        chk("mr_n3_rdata", b_rdata,  word(5));
        tick(); #1;
        chk("mr_n4_rv",    b_rvalid, 1);
        chk("mr_n4_rdata", b_rdata,  word(6));
        tick(); #1;
        chk("mr_n5_rv", b_rvalid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
